// File: rtl/flot_div_ctrl.sv
// Issue/return controller for a fixed-latency floating-point divider. IEEE special cases are
// resolved locally, tracked alongside the divider through a tag pipeline and merged back in order.
module flot_div_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned WIDTH_exp  = 8,
    parameter int unsigned WIDTH_mat  = 23,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic [WIDTH-1:0] div_op1,
    output logic [WIDTH-1:0] div_op2,
    output logic             div_ce,
    output logic             div_exce_in,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_exce_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_exce,
    output logic [2:0]       out_flags
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);

    localparam logic [2:0] FLG_NONE    = 3'b000;
    localparam logic [2:0] FLG_SPECIAL = 3'b001;
    localparam logic [2:0] FLG_DBZ     = 3'b011;
    localparam logic [2:0] FLG_INVALID = 3'b101;

    // ------------------------------------------------------------------
    // Handshakes and credit
    // ------------------------------------------------------------------
    logic          w_acc;
    logic          w_pop;
    logic [CW-1:0] r_credit;

    assign in_ready = (r_credit < CREDIT_MAX);
    assign w_acc    = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_credit <= '0;
        end else if (w_acc && !w_pop) begin
            r_credit <= r_credit + 1'b1;
        end else if (w_pop && !w_acc) begin
            r_credit <= r_credit - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand classification (denormals flush to zero)
    // ------------------------------------------------------------------
    logic                 w_s1;
    logic                 w_s2;
    logic [WIDTH_exp-1:0] w_e1;
    logic [WIDTH_exp-1:0] w_e2;
    logic [WIDTH_mat-1:0] w_m1;
    logic [WIDTH_mat-1:0] w_m2;
    logic                 w_zero1;
    logic                 w_zero2;
    logic                 w_inf1;
    logic                 w_inf2;
    logic                 w_nan1;
    logic                 w_nan2;
    logic                 w_sign;

    assign w_s1    = in_op1[WIDTH-1];
    assign w_s2    = in_op2[WIDTH-1];
    assign w_e1    = in_op1[WIDTH-2 -: WIDTH_exp];
    assign w_e2    = in_op2[WIDTH-2 -: WIDTH_exp];
    assign w_m1    = in_op1[WIDTH_mat-1:0];
    assign w_m2    = in_op2[WIDTH_mat-1:0];
    assign w_zero1 = (w_e1 == '0);
    assign w_zero2 = (w_e2 == '0);
    assign w_inf1  = (w_e1 == '1) && (w_m1 == '0);
    assign w_inf2  = (w_e2 == '1) && (w_m2 == '0);
    assign w_nan1  = (w_e1 == '1) && (w_m1 != '0);
    assign w_nan2  = (w_e2 == '1) && (w_m2 != '0);
    assign w_sign  = w_s1 ^ w_s2;

    logic [WIDTH-1:0] w_qnan;
    logic [WIDTH-1:0] w_inf_res;
    logic [WIDTH-1:0] w_zero_res;

    assign w_qnan     = {1'b0, {WIDTH_exp{1'b1}}, 1'b1, {(WIDTH_mat - 1){1'b0}}};
    assign w_inf_res  = {w_sign, {WIDTH_exp{1'b1}}, {WIDTH_mat{1'b0}}};
    assign w_zero_res = {w_sign, {(WIDTH - 1){1'b0}}};

    logic             w_spc;
    logic [WIDTH-1:0] w_spc_res;
    logic [2:0]       w_spc_flg;

    // Priority order matters: invalid cases first, then x/0, then the zero/inf outcomes.
    always_comb begin
        w_spc     = 1'b1;
        w_spc_res = '0;
        w_spc_flg = FLG_SPECIAL;
        if (w_nan1 || w_nan2 || (w_zero1 && w_zero2) || (w_inf1 && w_inf2)) begin
            w_spc_res = w_qnan;
            w_spc_flg = FLG_INVALID;
        end else if (w_zero2 && !w_inf1) begin
            w_spc_res = w_inf_res;
            w_spc_flg = FLG_DBZ;
        end else if (w_zero1 || w_inf2) begin
            w_spc_res = w_zero_res;
        end else if (w_inf1) begin
            w_spc_res = w_inf_res;
        end else begin
            w_spc     = 1'b0;
            w_spc_flg = FLG_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_div_op1;
    logic [WIDTH-1:0] r_div_op2;
    logic             r_div_ce;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_op1 <= '0;
            r_div_op2 <= '0;
            r_div_ce  <= 1'b0;
        end else begin
            r_div_ce <= w_acc;
            if (w_acc) begin
                r_div_op1 <= in_op1;
                r_div_op2 <= in_op2;
            end
        end
    end

    assign div_op1     = r_div_op1;
    assign div_op2     = r_div_op2;
    assign div_ce      = r_div_ce;
    assign div_exce_in = 1'b0;

    // ------------------------------------------------------------------
    // Tag pipeline: stage LATENCY lines up with the divider result
    // ------------------------------------------------------------------
    logic             r_tag_vld [LATENCY+1];
    logic             r_tag_spc [LATENCY+1];
    logic [WIDTH-1:0] r_tag_res [LATENCY+1];
    logic [2:0]       r_tag_flg [LATENCY+1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i <= LATENCY; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_spc[i] <= 1'b0;
                r_tag_res[i] <= '0;
                r_tag_flg[i] <= '0;
            end
        end else begin
            r_tag_vld[0] <= w_acc;
            r_tag_spc[0] <= w_spc;
            r_tag_res[0] <= w_spc_res;
            r_tag_flg[0] <= w_spc_flg;
            for (int unsigned i = 1; i <= LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_spc[i] <= r_tag_spc[i-1];
                r_tag_res[i] <= r_tag_res[i-1];
                r_tag_flg[i] <= r_tag_flg[i-1];
            end
        end
    end

    logic             w_push;
    logic [WIDTH-1:0] w_push_res;
    logic             w_push_exc;
    logic [2:0]       w_push_flg;

    assign w_push     = r_tag_vld[LATENCY];
    assign w_push_res = r_tag_spc[LATENCY] ? r_tag_res[LATENCY] : div_result;
    assign w_push_exc = !r_tag_spc[LATENCY] && div_exce_out;
    assign w_push_flg = r_tag_flg[LATENCY];

    // ------------------------------------------------------------------
    // Result FIFO; credit control guarantees it never overflows
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_fifo_res [FIFO_DEPTH];
    logic             r_fifo_exc [FIFO_DEPTH];
    logic [2:0]       r_fifo_flg [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_res[i] <= '0;
                r_fifo_exc[i] <= 1'b0;
                r_fifo_flg[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_res[r_wptr] <= w_push_res;
                r_fifo_exc[r_wptr] <= w_push_exc;
                r_fifo_flg[r_wptr] <= w_push_flg;
                r_wptr             <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_result = r_fifo_res[r_rptr];
    assign out_exce   = r_fifo_exc[r_rptr];
    assign out_flags  = r_fifo_flg[r_rptr];

endmodule

// File: tb/tb_flot_div_ctrl.sv
// Self-checking bench for flot_div_ctrl: a stand-in divider, a queue-based model of the
// controller's externally visible behaviour, and directed vectors with literal expectations.
module tb_flot_div_ctrl;

    localparam int unsigned LAT   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] EXC_OP = 32'h4120_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic        div_ce;
    logic        div_exce_in;
    logic [31:0] div_result;
    logic        div_exce_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_exce;
    logic [2:0]  out_flags;

    always #5 CLK = ~CLK;

    flot_div_ctrl #(
        .WIDTH      (32),
        .WIDTH_exp  (8),
        .WIDTH_mat  (23),
        .LATENCY    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op1       (in_op1),
        .in_op2       (in_op2),
        .div_op1      (div_op1),
        .div_op2      (div_op2),
        .div_ce       (div_ce),
        .div_exce_in  (div_exce_in),
        .div_result   (div_result),
        .div_exce_out (div_exce_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_exce     (out_exce),
        .out_flags    (out_flags)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Stand-in divider: known quotient for 6/2, otherwise a deterministic scramble.
    function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
    endfunction

    logic [31:0] dv_res [LAT];
    logic        dv_exc [LAT];

    always @(posedge CLK) begin
        for (int i = LAT - 1; i > 0; i--) begin
            dv_res[i] <= dv_res[i-1];
            dv_exc[i] <= dv_exc[i-1];
        end
        dv_res[0] <= div_ce ? fake_div(div_op1, div_op2) : 32'hDEAD_BEEF;
        dv_exc[0] <= div_ce && (div_op1 == EXC_OP);
    end

    assign div_result   = dv_res[LAT-1];
    assign div_exce_out = dv_exc[LAT-1];

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] res;
        logic        exc;
        logic [2:0]  flg;
        logic [31:0] rdy;
    } exp_t;

    function automatic bit f_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction
    function automatic bit f_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 23'h0;
    endfunction
    function automatic bit f_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 23'h0;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] rdy);
        exp_t e;
        logic sg;
        sg    = a[31] ^ b[31];
        e.rdy = rdy;
        e.exc = 1'b0;
        if (f_nan(a) || f_nan(b) || (f_zero(a) && f_zero(b)) || (f_inf(a) && f_inf(b))) begin
            e.res = 32'h7FC0_0000;
            e.flg = 3'b101;
        end else if (f_zero(b) && !f_inf(a)) begin
            e.res = {sg, 31'h7F80_0000};
            e.flg = 3'b011;
        end else if (f_zero(a) || f_inf(b)) begin
            e.res = {sg, 31'h0};
            e.flg = 3'b001;
        end else if (f_inf(a)) begin
            e.res = {sg, 31'h7F80_0000};
            e.flg = 3'b001;
        end else begin
            e.res = fake_div(a, b);
            e.exc = (a == EXC_OP);
            e.flg = 3'b000;
        end
        return e;
    endfunction

    exp_t        q[$];
    logic [31:0] edge_n;
    logic [31:0] last1;
    logic [31:0] last2;
    logic        exp_ce;
    int          dut_acc = 0;
    int          dut_pop = 0;

    // Checks the state after edge edge_n, then advances the model across the next edge.
    always @(negedge CLK) begin : compare
        logic exp_ov;
        logic m_acc;
        logic m_pop;
        if (RST) begin
            q.delete();
            edge_n = 0;
            last1  = 0;
            last2  = 0;
            exp_ce = 0;
        end else begin
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("div_ce", div_ce, exp_ce);
            chk("div_op1", div_op1, last1);
            chk("div_op2", div_op2, last2);
            chk("div_exce_in", div_exce_in, 1'b0);
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = (q[0].rdy <= edge_n);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_result", out_result, q[0].res);
                chk("out_exce", out_exce, q[0].exc);
                chk("out_flags", out_flags, q[0].flg);
            end
            if (in_valid && in_ready) dut_acc++;
            if (out_valid && out_ready) dut_pop++;
            m_acc = in_valid && (q.size() < DEPTH);
            m_pop = exp_ov && out_ready;
            if (m_pop) void'(q.pop_front());
            if (m_acc) begin
                q.push_back(model(in_op1, in_op2, edge_n + LAT + 2));
                last1 = in_op1;
                last2 = in_op2;
            end
            exp_ce = m_acc;
            edge_n = edge_n + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_op1   = a;
        in_op2   = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", done, 1'b1);
    endtask

    task automatic wait_out(input string name, input logic [31:0] r, input logic e,
                            input logic [2:0] f);
        bit found;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (out_valid) found = 1;
        end
        chk({name, "_seen"}, found, 1'b1);
        if (found) begin
            chk({name, "_res"}, out_result, r);
            chk({name, "_exce"}, out_exce, e);
            chk({name, "_flags"}, out_flags, f);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_in_ready"}, in_ready, 1'b1);
        chk({name, "_div_ce"}, div_ce, 1'b0);
        chk({name, "_out_valid"}, out_valid, 1'b0);
        chk({name, "_out_exce"}, out_exce, 1'b0);
        chk({name, "_div_exce_in"}, div_exce_in, 1'b0);
        chk({name, "_div_op1"}, div_op1, 32'h0);
        chk({name, "_div_op2"}, div_op2, 32'h0);
        chk({name, "_out_result"}, out_result, 32'h0);
        chk({name, "_out_flags"}, out_flags, 3'b000);
    endtask

    logic [31:0] vec_a [10];
    logic [31:0] vec_b [10];
    logic [31:0] vec_r [10];
    logic [2:0]  vec_f [10];

    initial begin
        int lat;
        int n;
        bit stale;

        vec_a[0] = 32'h3F80_0000; vec_b[0] = 32'h0000_0000; vec_r[0] = 32'h7F80_0000; vec_f[0] = 3'b011;
        vec_a[1] = 32'h8000_0000; vec_b[1] = 32'h0000_0000; vec_r[1] = 32'h7FC0_0000; vec_f[1] = 3'b101;
        vec_a[2] = 32'h7F80_0000; vec_b[2] = 32'hFF80_0000; vec_r[2] = 32'h7FC0_0000; vec_f[2] = 3'b101;
        vec_a[3] = 32'hFF80_0000; vec_b[3] = 32'h4000_0000; vec_r[3] = 32'hFF80_0000; vec_f[3] = 3'b001;
        vec_a[4] = 32'h4000_0000; vec_b[4] = 32'hFF80_0000; vec_r[4] = 32'h8000_0000; vec_f[4] = 3'b001;
        vec_a[5] = 32'h7FC0_0001; vec_b[5] = 32'h3F80_0000; vec_r[5] = 32'h7FC0_0000; vec_f[5] = 3'b101;
        vec_a[6] = 32'h0000_0001; vec_b[6] = 32'h3F80_0000; vec_r[6] = 32'h0000_0000; vec_f[6] = 3'b001;
        vec_a[7] = 32'h0000_0000; vec_b[7] = 32'hC000_0000; vec_r[7] = 32'h8000_0000; vec_f[7] = 3'b001;
        vec_a[8] = 32'h7F80_0000; vec_b[8] = 32'h0000_0000; vec_r[8] = 32'h7F80_0000; vec_f[8] = 3'b001;
        vec_a[9] = 32'hC040_0000; vec_b[9] = 32'h0000_0000; vec_r[9] = 32'hFF80_0000; vec_f[9] = 3'b011;

        in_valid  = 1'b0;
        in_op1    = '0;
        in_op2    = '0;
        out_ready = 1'b1;
        RST       = 1'b1;
        #1;
        chk_reset("rst0");
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // 6.0 / 2.0: single ce pulse, result LATENCY+1 edges after the accept edge.
        send(32'h40C0_0000, 32'h4000_0000);
        chk("t1_ce", div_ce, 1'b1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("t1_lat", lat, LAT + 1);
        chk("t1_res", out_result, 32'h4040_0000);
        chk("t1_flags", out_flags, 3'b000);
        chk("t1_exce", out_exce, 1'b0);

        // Special cases, issued in back-to-back pairs.
        for (int i = 0; i < 10; i += 2) begin
            send(vec_a[i], vec_b[i]);
            send(vec_a[i+1], vec_b[i+1]);
            wait_out($sformatf("spc%0d", i), vec_r[i], 1'b0, vec_f[i]);
            wait_out($sformatf("spc%0d", i + 1), vec_r[i+1], 1'b0, vec_f[i+1]);
        end
        repeat (4) @(posedge CLK);
        #1;

        // Backpressure: only DEPTH of 6 offered ops accepted.
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_op1   = 32'h3F80_0000 + (32'(i) << 20);
            in_op2   = 32'h4000_0000;
            if (in_ready) n++;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", n, 4);
        chk("bp_ready_low", in_ready, 1'b0);
        repeat (10) @(posedge CLK);
        #1;
        chk("bp_ready_still_low", in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_ready_back", in_ready, 1'b1);
        repeat (8) @(posedge CLK);
        #1;

        // Streaming from full credit with continuous valid/ready.
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 400 && n < 20; c++) begin
            if (n == 4) out_ready = 1'b1;
            in_valid = 1'b1;
            in_op1   = 32'h4000_0000 + (32'(n) << 16);
            in_op2   = (n % 5 == 4) ? 32'h0 : 32'h3FC0_0000;
            if (in_ready) n++;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        chk("stream_count", n, 20);
        repeat (20) @(posedge CLK);
        #1;
        chk("no_drop_dup", dut_pop, dut_acc);

        // Divider exception passes through only for normal ops.
        send(EXC_OP, 32'h4000_0000);
        send(32'h40C0_0000, 32'h4000_0000);
        send(EXC_OP, 32'h0000_0000);
        wait_out("exc_normal", fake_div(EXC_OP, 32'h4000_0000), 1'b1, 3'b000);
        wait_out("exc_next", 32'h4040_0000, 1'b0, 3'b000);
        wait_out("exc_special", 32'h7F80_0000, 1'b0, 3'b011);
        repeat (4) @(posedge CLK);
        #1;

        // Reset with three ops in flight.
        send(32'h4040_0000, 32'h3F80_0000);
        send(32'h4080_0000, 32'h3F80_0000);
        send(32'h40A0_0000, 32'h3F80_0000);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk_reset("rst1");
        repeat (2) @(posedge CLK);
        #1;
        RST   = 1'b0;
        stale = 0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (out_valid) stale = 1;
        end
        chk("no_stale", stale, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
